// File: rtl/axi_lite_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_write_queue
// Brief    : Command FIFO and one-at-a-time write sequencer feeding the
//            AXI4-Lite write master core, with failure counting and timeout.
// Revision : 1.0
// ============================================================================
module axi_lite_write_queue #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int ERR_CNT_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     s_cmd_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_cmd_strb,
    input  logic                          s_cmd_valid,
    output logic                          s_cmd_ready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_waddr,
    output logic [AXI_DATA_WIDTH-1:0]     m_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                          m_write,
    input  logic                          m_busy,
    input  logic                          m_write_failure,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          idle_o,
    output logic [ERR_CNT_WIDTH-1:0]      err_count_o,
    output logic                          err_sticky_o,
    output logic                          timeout_o,
    input  logic                          err_clear_i
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int ENT_W  = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + STRB_W;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [LVL_W-1:0]         C_LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]         C_LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0]         C_PTR_ONE  = PTR_W'(1);
    localparam logic [TO_W-1:0]          C_TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]          C_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]          C_TO_ONE   = TO_W'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] C_ERR_MAX  = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] C_ERR_ONE  = ERR_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ENT_W-1:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [TO_W-1:0]          r_to_cnt;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_empty;
    logic [ERR_CNT_WIDTH-1:0] w_err_base;
    logic [ERR_CNT_WIDTH-1:0] w_err_nxt;

    assign w_empty     = (fifo_level == '0);
    assign s_cmd_ready = (fifo_level != C_LVL_FULL);
    assign w_push      = s_cmd_valid && s_cmd_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !m_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_GUARD;
                end
            end
            // The core raises busy one cycle after the strobe, so busy is not sampled here.
            ST_GUARD: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!m_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_cmd_addr, s_cmd_data, s_cmd_strb};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            fifo_level <= '0;
            m_write    <= 1'b0;
            m_waddr    <= '0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            idle_o     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            m_write <= w_pop;
            idle_o  <= (r_state == ST_IDLE) && w_empty && !m_busy;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr                     <= r_rd_ptr + C_PTR_ONE;
                {m_waddr, m_wdata, m_wstrb}  <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   fifo_level <= fifo_level + C_LVL_ONE;
                2'b01:   fifo_level <= fifo_level - C_LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // A failure coinciding with a clear counts against the freshly cleared value.
    always_comb begin
        w_err_base = err_clear_i ? '0 : err_count_o;
        w_err_nxt  = w_err_base;
        if (m_write_failure && (w_err_base != C_ERR_MAX)) begin
            w_err_nxt = w_err_base + C_ERR_ONE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_count_o  <= '0;
            err_sticky_o <= 1'b0;
            r_to_cnt     <= '0;
            timeout_o    <= 1'b0;
        end else begin
            err_count_o  <= w_err_nxt;
            err_sticky_o <= m_write_failure || (err_sticky_o && !err_clear_i);
            if (w_pop) begin
                r_to_cnt <= '0;
            end else if ((r_state != ST_IDLE) && (r_to_cnt != C_TO_MAX)) begin
                r_to_cnt <= r_to_cnt + C_TO_ONE;
            end
            if ((TIMEOUT_CYCLES != 0) && (r_state != ST_IDLE) && (r_to_cnt == C_TO_LAST)) begin
                timeout_o <= 1'b1;
            end else if (err_clear_i) begin
                timeout_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_write_queue
// Brief    : Self-checking bench with a reactive core model and a command
//            scoreboard for axi_lite_write_queue.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_write_queue;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } cmd_t;

    typedef struct {
        cmd_t c;
        int   cyc;
        logic prev_busy;
        logic prev_write;
    } stb_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_cmd_addr = '0;
    logic [31:0] s_cmd_data = '0;
    logic [3:0]  s_cmd_strb = '0;
    logic        s_cmd_valid = 1'b0;
    logic        s_cmd_ready;
    logic [31:0] m_waddr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_write;
    logic        m_busy = 1'b0;
    logic        m_write_failure = 1'b0;
    logic [4:0]  fifo_level;
    logic        idle_o;
    logic [7:0]  err_count_o;
    logic        err_sticky_o;
    logic        timeout_o;
    logic        err_clear_i = 1'b0;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   busy_len = 2;
    bit   busy_force = 1'b0;
    bit   busy_rand = 1'b0;
    cmd_t exp_q[$];
    stb_t stb_q[$];

    axi_lite_write_queue #(
        .AXI_DATA_WIDTH (32),
        .AXI_ADDR_WIDTH (32),
        .FIFO_DEPTH     (16),
        .ERR_CNT_WIDTH  (8),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_cmd_addr      (s_cmd_addr),
        .s_cmd_data      (s_cmd_data),
        .s_cmd_strb      (s_cmd_strb),
        .s_cmd_valid     (s_cmd_valid),
        .s_cmd_ready     (s_cmd_ready),
        .m_waddr         (m_waddr),
        .m_wdata         (m_wdata),
        .m_wstrb         (m_wstrb),
        .m_write         (m_write),
        .m_busy          (m_busy),
        .m_write_failure (m_write_failure),
        .fifo_level      (fifo_level),
        .idle_o          (idle_o),
        .err_count_o     (err_count_o),
        .err_sticky_o    (err_sticky_o),
        .timeout_o       (timeout_o),
        .err_clear_i     (err_clear_i)
    );

    always #5 aclk = ~aclk;

    // Core model: busy rises the cycle after a strobe; every strobe is logged.
    initial begin
        int   busy_rem;
        logic prev_busy;
        logic prev_write;
        stb_t rec;
        busy_rem   = 0;
        prev_busy  = 1'b0;
        prev_write = 1'b0;
        forever begin
            @(posedge aclk);
            cyc++;
            #2;
            if (!aresetn) begin
                busy_rem = 0;
                m_busy   = 1'b0;
            end else if (busy_rem > 0) begin
                m_busy = 1'b1;
                busy_rem--;
            end else begin
                m_busy = busy_force;
            end
            if (m_write === 1'b1) begin
                rec.c          = {m_waddr, m_wdata, m_wstrb};
                rec.cyc        = cyc;
                rec.prev_busy  = prev_busy;
                rec.prev_write = prev_write;
                stb_q.push_back(rec);
                busy_rem = busy_rand ? int'($urandom_range(0, 4)) : busy_len;
            end
            prev_busy  = m_busy;
            prev_write = m_write;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.a = $urandom;
        c.d = $urandom;
        c.s = 4'($urandom);
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic push(input cmd_t c, output bit acc, output int acc_cyc);
        int n;
        s_cmd_addr  = c.a;
        s_cmd_data  = c.d;
        s_cmd_strb  = c.s;
        s_cmd_valid = 1'b1;
        n   = 0;
        acc = 1'b0;
        acc_cyc = -1;
        while (!acc && n < 300) begin
            acc     = s_cmd_ready;
            acc_cyc = cyc;
            tick(1);
            n++;
        end
        s_cmd_valid = 1'b0;
        if (acc) exp_q.push_back(c);
    endtask

    task automatic wait_strobes(input int n, input int bound, output bit ok);
        int k;
        k = 0;
        while (stb_q.size() < n && k < bound) begin
            tick(1);
            k++;
        end
        ok = (stb_q.size() >= n);
    endtask

    task automatic wait_idle(output bit ok);
        int k;
        int run;
        k   = 0;
        run = 0;
        while (run < 2 && k < 500) begin
            run = (idle_o === 1'b1) ? run + 1 : 0;
            tick(1);
            k++;
        end
        ok = (run >= 2);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick(3);
        n_total++;
        if ({s_cmd_ready, idle_o, m_write} !== 3'b110) $display("FAIL reset_flags: ready/idle/write=%b required 110", {s_cmd_ready, idle_o, m_write});
        else n_pass++;
        n_total++;
        if (fifo_level !== 5'd0) $display("FAIL reset_level: got %0d required 0", fifo_level);
        else n_pass++;
        n_total++;
        if ({err_count_o, err_sticky_o, timeout_o} !== 10'd0) $display("FAIL reset_err: count=%0d sticky=%b timeout=%b required 0", err_count_o, err_sticky_o, timeout_o);
        else n_pass++;
        n_total++;
        if ({m_waddr, m_wdata, m_wstrb} !== 68'd0) $display("FAIL reset_wbus: got %h required 0", {m_waddr, m_wdata, m_wstrb});
        else n_pass++;
        aresetn = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        cmd_t c;
        bit   acc;
        int   t;
        exp_q.delete();
        stb_q.delete();
        busy_len = 2;
        c = '{a: 32'h4000_0010, d: 32'hDEAD_BEEF, s: 4'hF};
        push(c, acc, t);
        tick(8);
        n_total++;
        if (!acc || stb_q.size() != 1) $display("FAIL single_count: accepted=%0d strobes=%0d required 1 and 1", acc, stb_q.size());
        else n_pass++;
        if (stb_q.size() >= 1) begin
            n_total++;
            if (stb_q[0].cyc != t + 2) $display("FAIL single_latency: strobe cycle %0d required %0d", stb_q[0].cyc, t + 2);
            else n_pass++;
            n_total++;
            if (stb_q[0].c !== c) $display("FAIL single_data: got %h required %h", stb_q[0].c, c);
            else n_pass++;
        end
        n_total++;
        if (fifo_level !== 5'd0) $display("FAIL single_level: got %0d required 0", fifo_level);
        else n_pass++;
    endtask

    task automatic test_fill_drain();
        bit ok;
        bit all_acc;
        bit acc;
        int t;
        wait_idle(ok);
        exp_q.delete();
        stb_q.delete();
        busy_force = 1'b1;
        all_acc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(rand_cmd(), acc, t);
            all_acc &= acc;
        end
        n_total++;
        if (!all_acc || s_cmd_ready !== 1'b0 || fifo_level !== 5'd16) $display("FAIL fill_full: accepted=%0d ready=%b level=%0d required 1, 0, 16", all_acc, s_cmd_ready, fifo_level);
        else n_pass++;
        n_total++;
        if (stb_q.size() != 0) $display("FAIL fill_no_issue_while_busy: strobes=%0d required 0", stb_q.size());
        else n_pass++;
        busy_len   = 3;
        busy_force = 1'b0;
        wait_strobes(16, 400, ok);
        n_total++;
        if (!ok) $display("FAIL drain_count: strobes=%0d required 16", stb_q.size());
        else n_pass++;
        for (int i = 0; i < 16 && i < stb_q.size(); i++) begin
            n_total++;
            if (stb_q[i].c !== exp_q[i] || stb_q[i].prev_busy !== 1'b0 || stb_q[i].prev_write !== 1'b0)
                $display("FAIL drain_entry%0d: got %h busy_before=%b write_before=%b required %h 0 0", i, stb_q[i].c, stb_q[i].prev_busy, stb_q[i].prev_write, exp_q[i]);
            else n_pass++;
        end
        wait_idle(ok);
        n_total++;
        if (!ok || fifo_level !== 5'd0 || s_cmd_ready !== 1'b1) $display("FAIL drain_empty: idle=%0d level=%0d ready=%b required 1 0 1", ok, fifo_level, s_cmd_ready);
        else n_pass++;
    endtask

    task automatic test_push_pop_same();
        bit ok;
        bit acc;
        int t;
        wait_idle(ok);
        exp_q.delete();
        stb_q.delete();
        busy_len   = 0;
        busy_force = 1'b1;
        for (int i = 0; i < 3; i++) push(rand_cmd(), acc, t);
        n_total++;
        if (fifo_level !== 5'd3) $display("FAIL pp_prefill: level=%0d required 3", fifo_level);
        else n_pass++;
        busy_force = 1'b0;
        push(rand_cmd(), acc, t);
        busy_force = 1'b1;
        n_total++;
        if (!acc || fifo_level !== 5'd3) $display("FAIL pp_level: accepted=%0d level=%0d required 1 and 3", acc, fifo_level);
        else n_pass++;
        busy_len   = 1;
        busy_force = 1'b0;
        wait_strobes(4, 200, ok);
        n_total++;
        if (!ok) $display("FAIL pp_drain_count: strobes=%0d required 4", stb_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < stb_q.size(); i++) begin
            n_total++;
            if (stb_q[i].c !== exp_q[i]) $display("FAIL pp_order%0d: got %h required %h", i, stb_q[i].c, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        bit ok;
        bit acc;
        bit all_acc;
        int t;
        wait_idle(ok);
        exp_q.delete();
        stb_q.delete();
        busy_rand = 1'b1;
        all_acc   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(rand_cmd(), acc, t);
            all_acc &= acc;
        end
        wait_strobes(40, 2000, ok);
        busy_rand = 1'b0;
        n_total++;
        if (!all_acc || !ok) $display("FAIL wrap_count: accepted=%0d strobes=%0d required 1 and 40", all_acc, stb_q.size());
        else n_pass++;
        for (int i = 0; i < 40 && i < stb_q.size(); i++) begin
            n_total++;
            if (stb_q[i].c !== exp_q[i] || stb_q[i].prev_busy !== 1'b0 ||
                (i > 0 && stb_q[i].cyc - stb_q[i-1].cyc < 3))
                $display("FAIL wrap_entry%0d: got %h busy_before=%b gap=%0d required %h 0 >=3", i, stb_q[i].c, stb_q[i].prev_busy, (i > 0) ? stb_q[i].cyc - stb_q[i-1].cyc : 3, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        int model_cnt;
        err_clear_i = 1'b1;
        tick(1);
        err_clear_i = 1'b0;
        n_total++;
        if (err_count_o !== 8'd0 || err_sticky_o !== 1'b0 || timeout_o !== 1'b0) $display("FAIL err_clear: count=%0d sticky=%b timeout=%b required 0 0 0", err_count_o, err_sticky_o, timeout_o);
        else n_pass++;
        model_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            m_write_failure = 1'b1;
            tick(1);
            model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
            m_write_failure = 1'b0;
            tick($urandom_range(0, 1));
            if (i == 4) begin
                n_total++;
                if (err_count_o !== 8'(model_cnt) || err_sticky_o !== 1'b1) $display("FAIL err_count5: count=%0d sticky=%b required %0d 1", err_count_o, err_sticky_o, model_cnt);
                else n_pass++;
            end
        end
        n_total++;
        if (err_count_o !== 8'd255 || err_sticky_o !== 1'b1) $display("FAIL err_saturate: count=%0d sticky=%b required 255 1", err_count_o, err_sticky_o);
        else n_pass++;
        err_clear_i     = 1'b1;
        m_write_failure = 1'b1;
        tick(1);
        err_clear_i     = 1'b0;
        m_write_failure = 1'b0;
        n_total++;
        if (err_count_o !== 8'd1 || err_sticky_o !== 1'b1) $display("FAIL err_clear_and_fail: count=%0d sticky=%b required 1 1", err_count_o, err_sticky_o);
        else n_pass++;
        err_clear_i = 1'b1;
        tick(1);
        err_clear_i = 1'b0;
        n_total++;
        if (err_count_o !== 8'd0 || err_sticky_o !== 1'b0) $display("FAIL err_clear_only: count=%0d sticky=%b required 0 0", err_count_o, err_sticky_o);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit   ok;
        bit   acc;
        int   t;
        int   s;
        cmd_t c;
        wait_idle(ok);
        exp_q.delete();
        stb_q.delete();
        busy_len = 30;
        push(rand_cmd(), acc, t);
        wait_strobes(1, 20, ok);
        n_total++;
        if (!ok) $display("FAIL to_first_strobe: strobes=%0d required 1", stb_q.size());
        else n_pass++;
        s = ok ? stb_q[0].cyc : cyc;
        while (cyc < s + 7) tick(1);
        n_total++;
        if (timeout_o !== 1'b0) $display("FAIL to_early: timeout=%b at 7 cycles required 0", timeout_o);
        else n_pass++;
        while (cyc < s + 9) tick(1);
        n_total++;
        if (timeout_o !== 1'b1) $display("FAIL to_set: timeout=%b at 9 cycles required 1", timeout_o);
        else n_pass++;
        wait_idle(ok);
        busy_len = 2;
        c = rand_cmd();
        push(c, acc, t);
        wait_strobes(2, 40, ok);
        n_total++;
        if (!ok || stb_q[1].c !== c) $display("FAIL to_next_issue: strobes=%0d required 2 with %h", stb_q.size(), c);
        else n_pass++;
        wait_idle(ok);
        n_total++;
        if (timeout_o !== 1'b1) $display("FAIL to_sticky: timeout=%b required 1", timeout_o);
        else n_pass++;
        err_clear_i = 1'b1;
        tick(1);
        err_clear_i = 1'b0;
        n_total++;
        if (timeout_o !== 1'b0) $display("FAIL to_clear: timeout=%b required 0", timeout_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit   ok;
        bit   acc;
        int   t;
        cmd_t c;
        wait_idle(ok);
        exp_q.delete();
        stb_q.delete();
        busy_len = 40;
        for (int i = 0; i < 6; i++) push(rand_cmd(), acc, t);
        wait_strobes(1, 20, ok);
        tick(4);
        n_total++;
        if (fifo_level !== 5'd5 || m_busy !== 1'b1) $display("FAIL rst_mid_pre: level=%0d busy=%b required 5 1", fifo_level, m_busy);
        else n_pass++;
        #2;
        aresetn = 1'b0;
        #1;
        n_total++;
        if (fifo_level !== 5'd0 || s_cmd_ready !== 1'b1 || idle_o !== 1'b1 || m_write !== 1'b0) $display("FAIL rst_mid_now: level=%0d ready=%b idle=%b write=%b required 0 1 1 0", fifo_level, s_cmd_ready, idle_o, m_write);
        else n_pass++;
        n_total++;
        if ({m_waddr, m_wdata, m_wstrb} !== 68'd0) $display("FAIL rst_mid_wbus: got %h required 0", {m_waddr, m_wdata, m_wstrb});
        else n_pass++;
        exp_q.delete();
        stb_q.delete();
        tick(2);
        aresetn = 1'b1;
        tick(10);
        n_total++;
        if (stb_q.size() != 0 || fifo_level !== 5'd0) $display("FAIL rst_mid_quiet: strobes=%0d level=%0d required 0 0", stb_q.size(), fifo_level);
        else n_pass++;
        busy_len = 2;
        c = rand_cmd();
        push(c, acc, t);
        wait_strobes(1, 20, ok);
        n_total++;
        if (!ok || stb_q[0].c !== c || stb_q[0].cyc != t + 2) $display("FAIL rst_mid_resume: strobes=%0d required 1 with %h at cycle %0d", stb_q.size(), c, t + 2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_push_pop_same();
        test_wrap();
        test_errors();
        test_timeout();
        test_reset_mid();
        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
